// File: rtl/prog_seq_pkg.sv
// Shared state encoding and program base-address table for the run sequencer.
package prog_seq_pkg;

  localparam int PROG_IDX_W = 2;
  localparam int MAX_PROGS  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    NEXT   = 3'd4,
    FIN    = 3'd5
  } seq_state_t;

  // Packed MSB-first: entry 0 is the rightmost element.
  localparam logic [MAX_PROGS-1:0][15:0] BASE = {16'd0, 16'd342, 16'd171, 16'd0};

  function automatic logic [15:0] base_addr(input logic [PROG_IDX_W-1:0] idx);
    return BASE[idx];
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Clearable up-counter with a limit compare; hit_o marks the enabled cycle
// whose increment brings the count up to limit_i.
module seq_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign hit_o   = ((cnt_q + W'(1)) == limit_i);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: holds the core in init, launches each program's base address
// through the PC jump port, and reports per-program RUN cycle counts.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int               NUM_PROGS   = 3,
  parameter int               ADDR_W      = 16,
  parameter int               CNT_W       = 16,
  parameter int               INIT_CYCLES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic                  CLK,
  input  logic                  init,
  input  logic                  start,
  input  logic                  core_halt,
  output logic                  core_init,
  output logic                  seq_jump_en,
  output logic [ADDR_W-1:0]     seq_target,
  output logic                  busy,
  output logic                  done,
  output logic [PROG_IDX_W-1:0] prog_idx,
  output logic                  result_valid,
  output logic [CNT_W-1:0]      result_cycles,
  output logic                  result_timeout
);

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] limit_s;
  logic             cnt_hit_s;
  logic             cnt_en_s;

  // HOLD and RUN never overlap, so one counter serves both; it is cleared in every other state.
  assign cnt_en_s = (state_q == HOLD) || (state_q == RUN);
  assign limit_s  = (state_q == HOLD) ? CNT_W'(INIT_CYCLES) : TIMEOUT;

  seq_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk_i   (CLK),
    .rst_i   (init),
    .clear_i (!cnt_en_s),
    .en_i    (cnt_en_s),
    .limit_i (limit_s),
    .count_o (cnt_s),
    .hit_o   (cnt_hit_s)
  );

  always_ff @(posedge CLK) begin
    if (init) begin
      state_q        <= IDLE;
      core_init      <= 1'b0;
      seq_jump_en    <= 1'b0;
      seq_target     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      prog_idx       <= '0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      seq_jump_en  <= 1'b0;
      seq_target   <= '0;
      case (state_q)
        IDLE, FIN: begin
          if (start) begin
            state_q   <= HOLD;
            prog_idx  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            core_init <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_hit_s) begin
            state_q     <= LAUNCH;
            core_init   <= 1'b0;
            seq_jump_en <= 1'b1;
            seq_target  <= ADDR_W'(base_addr(prog_idx));
          end
        end
        LAUNCH: state_q <= RUN;
        RUN: begin
          // Halt takes priority over a timeout landing on the same cycle.
          if (core_halt || cnt_hit_s) begin
            state_q        <= NEXT;
            result_valid   <= 1'b1;
            result_cycles  <= cnt_s + CNT_W'(1);
            result_timeout <= !core_halt;
          end
        end
        NEXT: begin
          if (prog_idx == PROG_IDX_W'(NUM_PROGS - 1)) begin
            state_q <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q   <= HOLD;
            prog_idx  <= prog_idx + PROG_IDX_W'(1);
            core_init <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench: builds the expected per-cycle output timeline from program
// durations and compares every cycle against the sequencer.
module tb_prog_sequencer;

  localparam int T = 20;

  logic        CLK = 1'b0;
  logic        init, start, core_halt;
  logic        core_init, seq_jump_en, busy, done, result_valid, result_timeout;
  logic [15:0] seq_target, result_cycles;
  logic [1:0]  prog_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        ci;
    logic        je;
    logic [15:0] tg;
    logic        bz;
    logic        dn;
    logic [1:0]  idx;
    logic        rv;
    logic [15:0] rc;
    logic        rt;
  } obs_t;

  obs_t        q_exp[$];
  logic        q_halt[$];
  logic        q_start[$];
  logic [15:0] exp_rc = 16'd0;
  logic        exp_rt = 1'b0;

  prog_sequencer #(.NUM_PROGS(3), .ADDR_W(16), .CNT_W(16), .INIT_CYCLES(2), .TIMEOUT(16'd20)) dut (
    .CLK(CLK), .init(init), .start(start), .core_halt(core_halt),
    .core_init(core_init), .seq_jump_en(seq_jump_en), .seq_target(seq_target),
    .busy(busy), .done(done), .prog_idx(prog_idx), .result_valid(result_valid),
    .result_cycles(result_cycles), .result_timeout(result_timeout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] base_of(input int p);
    case (p)
      0:       return 16'd0;
      1:       return 16'd171;
      2:       return 16'd342;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic rb(input bit en);
    return en ? 1'($urandom_range(1, 0)) : 1'b0;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = {core_init, seq_jump_en, seq_target, busy, done, prog_idx, result_valid, result_cycles, result_timeout};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic ci, input logic je, input logic [15:0] tg, input logic bz,
                      input logic dn, input int idx, input logic rv, input logic h, input logic s);
    obs_t e;
    e.ci = ci; e.je = je; e.tg = tg; e.bz = bz; e.dn = dn; e.idx = 2'(idx);
    e.rv = rv; e.rc = exp_rc; e.rt = exp_rt;
    q_exp.push_back(e);
    q_halt.push_back(h);
    q_start.push_back(s);
  endtask

  // One full start-to-FIN run; halt_at > T means the program never halts.
  task automatic play(input int h0, input int h1, input int h2, input bit noise, input string name);
    int h[3];
    int n;
    h = '{h0, h1, h2};
    q_exp.delete(); q_halt.delete(); q_start.delete();
    for (int p = 0; p < 3; p++) begin
      n = (h[p] <= T) ? h[p] : T;
      for (int c = 0; c < 2; c++) push(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, p, 1'b0, rb(noise), rb(noise));
      push(1'b0, 1'b1, base_of(p), 1'b1, 1'b0, p, 1'b0, rb(noise), rb(noise));
      for (int r = 1; r <= n; r++) push(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, p, 1'b0, (r == h[p]), rb(noise));
      exp_rc = 16'(n);
      exp_rt = (h[p] > T);
      push(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, p, 1'b1, rb(noise), rb(noise));
    end
    push(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 2, 1'b0, rb(noise), 1'b0);
    @(negedge CLK);
    start     = 1'b1;
    core_halt = rb(noise);
    for (int i = 0; i < q_exp.size(); i++) begin
      @(negedge CLK);
      check($sformatf("%s_c%0d", name, i + 1), q_exp[i]);
      start     = q_start[i];
      core_halt = q_halt[i];
    end
  endtask

  initial begin
    obs_t zero;
    zero      = '0;
    init      = 1'b1;
    start     = 1'b0;
    core_halt = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_hold", zero);
    init = 1'b0;
    @(negedge CLK);
    check("reset_idle", zero);

    play(10, 10, 10, 1'b0, "single");

    // Abort mid-RUN with a halt on the same edge as the reset.
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    init      = 1'b1;
    core_halt = 1'b1;
    @(negedge CLK);
    check("abort_1", zero);
    core_halt = 1'b0;
    @(negedge CLK);
    check("abort_2", zero);
    init = 1'b0;
    exp_rc = 16'd0;
    exp_rt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("abort_idle%0d", i), zero);
    end

    play(25, 25, 25, 1'b0, "timeout");
    play(20, 20, 20, 1'b0, "tie");
    play(19, 21, 1, 1'b1, "edge_noise");
    play(3, 10, 7, 1'b1, "restart");
    for (int k = 0; k < 6; k++) begin
      play(int'($urandom_range(25, 1)), int'($urandom_range(25, 1)), int'($urandom_range(25, 1)),
           1'b1, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
